// File: rtl/mem_hex_dumper.sv
// Streams a range of RAM words as lowercase ASCII hex lines.
// The output is a hex-loader-compatible text stream, one byte per handshake.
module mem_hex_dumper #(
    parameter int          ADDR_W = 10,
    parameter int          DATA_W = 32,
    parameter logic [7:0]  EOL    = 8'h0A
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int NIB = DATA_W / 4;
    localparam int CW  = $clog2(NIB + 1);
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_EMIT,
        S_EOLS,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
    endfunction

    // State and datapath registers; reset abandons any partial line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            shift_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic; the address only moves when a new read is issued.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    remain_d = word_count;
                    if (word_count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = base_addr;
                        state_d = S_READ;
                    end
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                shift_d = mem_rdata;
                cnt_d   = '0;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (tx_ready) begin
                    shift_d = {shift_q[DATA_W-5:0], 4'h0};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = S_EOLS;
                end
            end
            S_EOLS: begin
                if (tx_ready) begin
                    remain_d = remain_q - 1'b1;
                    if (remain_q == (ADDR_W+1)'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode straight from state so reset clears them at once.
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        mem_rd_en = (state_q == S_READ);
        mem_addr  = addr_q;
        tx_valid  = (state_q == S_EMIT) || (state_q == S_EOLS);
        tx_data   = 8'h00;
        if (state_q == S_EMIT) tx_data = hex_char(shift_q[DATA_W-1 -: 4]);
        if (state_q == S_EOLS) tx_data = EOL;
    end

endmodule

// File: tb/tb_mem_hex_dumper.sv
// Bench for mem_hex_dumper: RAM model, byte/address scoreboards,
// table of dump cases plus hand-written reset and literal sequences.
module tb_mem_hex_dumper;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] word_count;
    logic        busy;
    logic        done;
    logic [9:0]  mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    mem_hex_dumper dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_rdata  (mem_rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [1024];

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic [9:0]  base;
        logic [10:0] cnt;
        bit          rnd;
        bit          poke;
        int          exp_done;
        int          exp_first;
    } vec_t;

    vec_t vecs [6];

    logic [7:0] exp_q [$];
    logic [9:0] addr_q [$];

    int  n_cmp;
    int  n_bad;
    bit  mon_en;
    bit  stall_q;
    logic [7:0] hold_q;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] v);
        if (v > 4'd9) return 8'd97 + 8'(v - 4'd10);
        return 8'd48 + 8'(v);
    endfunction

    task automatic push_word(input logic [31:0] w);
        for (int k = 7; k >= 0; k--) exp_q.push_back(hexc(w[4*k +: 4]));
        exp_q.push_back(8'h0A);
    endtask

    // Monitor: checks reads and accepted bytes against the scoreboards.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_rd_en) begin
                if (addr_q.size() == 0) bad("rd_extra");
                else chk("rd_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
            end
            if (stall_q) chk("hold", {tx_valid, tx_data}, {1'b1, hold_q});
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) bad("byte_extra");
                else chk("byte", 64'(tx_data), 64'(exp_q.pop_front()));
            end
            stall_q = tx_valid && !tx_ready;
            hold_q  = tx_data;
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic run_dump(input logic [9:0] b, input logic [10:0] n,
                            input bit rnd, input bit poke,
                            input int exp_done, input int exp_first,
                            input bit model);
        int done_c;
        int busy_n;
        int first_c;
        int budget;
        logic [9:0] a;
        if (model) begin
            for (int i = 0; i < int'(n); i++) begin
                a = b + 10'(i);
                addr_q.push_back(a);
                push_word(mem[a]);
            end
        end
        done_c  = -1;
        busy_n  = 0;
        first_c = -1;
        budget  = int'(n) * 40 + 20;
        base_addr  = b;
        word_count = n;
        start      = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            start = poke && (c == 5);
            if (poke) begin
                base_addr  = 10'h300;
                word_count = 11'd5;
            end
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (busy) busy_n++;
            if (tx_valid && first_c < 0) first_c = c;
            if (done) begin
                done_c = c;
                break;
            end
        end
        if (done_c < 0) begin
            bad("timeout");
            exp_q.delete();
            addr_q.delete();
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("done_pulse", {done, busy}, 2'b00);
        chk("busy_len", 64'(busy_n), 64'(done_c));
        if (exp_done >= 0) chk("done_cyc", 64'(done_c), 64'(exp_done));
        if (exp_first != -2) chk("first_tx", 64'(first_c), 64'(exp_first));
        chk("bytes_left", 64'(exp_q.size()), 64'd0);
        chk("reads_left", 64'(addr_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    logic [7:0] lit [9];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        mon_en = 1'b0;
        stall_q = 1'b0;
        hold_q = 8'h00;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        tx_ready = 1'b1;
        reset_n = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[5]     = 32'h1234abcd;
        mem[10'h040] = 32'h0f9a5e00;
        mem[10'h041] = 32'hffffffff;
        lit = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h61, 8'h62, 8'h63, 8'h64, 8'h0A};

        vecs[0] = '{10'h010, 11'd0,    1'b0, 1'b0, 1,     -1};
        vecs[1] = '{10'h040, 11'd2,    1'b1, 1'b0, -1,    -2};
        vecs[2] = '{10'h3FE, 11'd3,    1'b0, 1'b0, 34,    3};
        vecs[3] = '{10'h080, 11'd2,    1'b0, 1'b1, 23,    3};
        vecs[4] = '{10'h200, 11'd4,    1'b1, 1'b1, -1,    -2};
        vecs[5] = '{10'h123, 11'd1024, 1'b0, 1'b0, 11265, 3};

        #12;
        chk("reset_out", {busy, done, mem_rd_en, tx_valid, mem_addr, tx_data},
            '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        for (int i = 0; i < 9; i++) exp_q.push_back(lit[i]);
        addr_q.push_back(10'd5);
        run_dump(10'd5, 11'd1, 1'b0, 1'b0, 12, 3, 1'b0);

        for (int v = 0; v < 6; v++) begin
            run_dump(vecs[v].base, vecs[v].cnt, vecs[v].rnd, vecs[v].poke,
                     vecs[v].exp_done, vecs[v].exp_first, 1'b1);
        end

        for (int i = 0; i < 3; i++) begin
            addr_q.push_back(10'h020 + 10'(i));
            push_word(mem[10'h020 + 10'(i)]);
        end
        tx_ready   = 1'b1;
        base_addr  = 10'h020;
        word_count = 11'd3;
        start      = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk("pre_rst_left", 64'(exp_q.size()), 64'd14);
        #2;
        mon_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_rst", {busy, done, mem_rd_en, tx_valid, mem_addr, tx_data},
            '0);
        exp_q.delete();
        addr_q.delete();
        @(posedge clk);
        #1;
        chk("rst_hold", {busy, tx_valid}, 2'b00);
        reset_n = 1'b1;
        mon_en = 1'b1;
        run_dump(10'h040, 11'd2, 1'b0, 1'b0, 23, 3, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
